// File: rtl/clk_div_ratio_ctrl_if.sv
// Config handshake bundle for the ratio controller.
// The master offers half-periods; the slave answers with ready/err.
interface clk_div_ratio_ctrl_if #(
   parameter int CW = 4
);
   logic          cfg_valid;
   logic [CW-1:0] cfg_half;
   logic          cfg_ready;
   logic          cfg_err;

   modport master (
      output cfg_valid,
      output cfg_half,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_half,
      output cfg_ready,
      output cfg_err
   );
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Glitch-free even-ratio divider front end.
// Ratio changes and stops land only on output period boundaries.
module clk_div_ratio_ctrl #(
   parameter int CW           = 4,
   parameter int MAX_HALF     = 8,
   parameter int DEFAULT_HALF = 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                enable,
   clk_div_ratio_ctrl_if.slave cfg,
   output logic                clk_out,
   output logic                period_start,
   output logic [CW-1:0]       cur_half,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_STOP,
      ST_RUN,
      ST_DRAIN
   } state_e;

   localparam logic [CW-1:0] MAX_H = CW'(MAX_HALF);
   localparam logic [CW-1:0] DEF_H = CW'(DEFAULT_HALF);
   localparam logic [CW-1:0] ONE   = CW'(1);

   state_e        state_q, state_d;
   logic [CW-1:0] hc_q, hc_d;
   logic          clk_out_q, clk_out_d;
   logic          ps_q, ps_d;
   logic [CW-1:0] cur_half_q, cur_half_d;
   logic [CW-1:0] pend_half_q, pend_half_d;
   logic          busy_q, busy_d;
   logic          cfg_err_q, cfg_err_d;

   logic [CW-1:0] half_m1;
   logic          last;
   logic          bnd;
   logic          accept;
   logic          legal;
   logic          apply;

   // cur_half is never 0, so the subtraction cannot wrap
   assign half_m1 = cur_half_q - ONE;
   assign last    = (hc_q == half_m1);
   assign bnd     = ~clk_out_q & last;
   assign accept  = cfg.cfg_valid & ~busy_q;
   assign legal   = (cfg.cfg_half != '0) &&
                    (cfg.cfg_half <= MAX_H);

   always_comb begin
      state_d     = state_q;
      hc_d        = hc_q;
      clk_out_d   = clk_out_q;
      ps_d        = 1'b0;
      cur_half_d  = cur_half_q;
      pend_half_d = pend_half_q;
      busy_d      = busy_q;
      cfg_err_d   = 1'b0;
      apply       = 1'b0;

      unique case (state_q)
         ST_STOP: begin
            clk_out_d = 1'b0;
            hc_d      = '0;
            apply     = busy_q;
            if (enable) begin
               state_d   = ST_RUN;
               clk_out_d = 1'b1;
               ps_d      = 1'b1;
            end
         end
         ST_RUN, ST_DRAIN: begin
            if (bnd) begin
               hc_d  = '0;
               apply = busy_q;
               if (enable) begin
                  state_d   = ST_RUN;
                  clk_out_d = 1'b1;
                  ps_d      = 1'b1;
               end else begin
                  state_d   = ST_STOP;
                  clk_out_d = 1'b0;
               end
            end else if (last) begin
               hc_d      = '0;
               clk_out_d = ~clk_out_q;
               state_d   = enable ? ST_RUN : ST_DRAIN;
            end else begin
               hc_d    = hc_q + ONE;
               state_d = enable ? ST_RUN : ST_DRAIN;
            end
         end
         default: begin
            state_d   = ST_STOP;
            clk_out_d = 1'b0;
            hc_d      = '0;
         end
      endcase

      if (apply) begin
         cur_half_d = pend_half_q;
         busy_d     = 1'b0;
      end

      // accept needs busy_q low, so it never collides with apply
      if (accept) begin
         if (legal) begin
            pend_half_d = cfg.cfg_half;
            busy_d      = 1'b1;
         end else begin
            cfg_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_STOP;
         hc_q        <= '0;
         clk_out_q   <= 1'b0;
         ps_q        <= 1'b0;
         cur_half_q  <= DEF_H;
         pend_half_q <= '0;
         busy_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hc_q        <= hc_d;
         clk_out_q   <= clk_out_d;
         ps_q        <= ps_d;
         cur_half_q  <= cur_half_d;
         pend_half_q <= pend_half_d;
         busy_q      <= busy_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign clk_out       = clk_out_q;
   assign period_start  = ps_q;
   assign cur_half      = cur_half_q;
   assign busy          = busy_q;
   assign cfg.cfg_ready = ~busy_q;
   assign cfg.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Bench for clk_div_ratio_ctrl: directed steps then random traffic,
// compared every cycle against a period-position reference model.
module tb_clk_div_ratio_ctrl;
   localparam int CW       = 4;
   localparam int MAX_HALF = 8;
   localparam int DEF      = 1;

   logic          clk = 1'b0;
   logic          resetn;
   logic          enable;
   logic          clk_out;
   logic          period_start;
   logic [CW-1:0] cur_half;
   logic          busy;

   int checks = 0;
   int errors = 0;

   clk_div_ratio_ctrl_if #(.CW(CW)) cfg_if ();

   clk_div_ratio_ctrl #(
      .CW(CW),
      .MAX_HALF(MAX_HALF),
      .DEFAULT_HALF(DEF)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .enable(enable),
      .cfg(cfg_if.slave),
      .clk_out(clk_out),
      .period_start(period_start),
      .cur_half(cur_half),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // model: position within the current full period of 2*half cycles
   bit m_run, m_pv, m_err, m_ps, m_out;
   int m_pos, m_half, m_pend;

   task automatic model_step(input bit rn, input bit en,
                             input bit v, input int h);
      bit lg, rdy;
      lg  = (h >= 1) && (h <= MAX_HALF);
      rdy = !m_pv;
      if (!rn) begin
         m_run = 0; m_pos = 0; m_half = DEF;
         m_pv = 0; m_err = 0; m_ps = 0; m_out = 0;
         return;
      end
      m_err = v && rdy && !lg;
      m_ps  = 0;
      if (!m_run) begin
         if (m_pv) begin m_half = m_pend; m_pv = 0; end
         if (en) begin m_run = 1; m_pos = 0; m_ps = 1; end
      end else if (m_pos == 2 * m_half - 1) begin
         if (m_pv) begin m_half = m_pend; m_pv = 0; end
         if (en) begin m_pos = 0; m_ps = 1; end
         else m_run = 0;
      end else begin
         m_pos++;
      end
      m_out = m_run && (m_pos < m_half);
      if (v && rdy && lg) begin m_pv = 1; m_pend = h; end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit rn, input bit en,
                       input bit v, input int h);
      resetn           = rn;
      enable           = en;
      cfg_if.cfg_valid = v;
      cfg_if.cfg_half  = CW'(h);
      @(posedge clk);
      model_step(rn, en, v, h);
      #1;
      chk("clk_out",      int'(clk_out),          int'(m_out));
      chk("period_start", int'(period_start),     int'(m_ps));
      chk("cur_half",     int'(cur_half),         m_half);
      chk("busy",         int'(busy),             int'(m_pv));
      chk("cfg_ready",    int'(cfg_if.cfg_ready), int'(!m_pv));
      chk("cfg_err",      int'(cfg_if.cfg_err),   int'(m_err));
   endtask

   task automatic idle(input int n, input bit en);
      for (int i = 0; i < n; i++) step(1, en, 0, 0);
   endtask

   initial begin
      resetn           = 1'b0;
      enable           = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_half  = '0;
      m_half = DEF;
      m_pend = 0;

      step(0, 0, 0, 0);
      step(0, 1, 1, 3);
      idle(6, 1);

      // request 3 during a high half of the div-2 waveform
      for (int i = 0; i < 4 && !m_out; i++) step(1, 1, 0, 0);
      step(1, 1, 1, 3);
      idle(14, 1);

      step(1, 1, 1, 0);
      idle(1, 1);
      step(1, 1, 1, 9);
      idle(2, 1);

      // drain to stop, load 2, then drop at first high cycle
      idle(8, 0);
      step(1, 0, 1, 2);
      idle(2, 0);
      step(1, 1, 0, 0);
      idle(7, 0);
      idle(5, 1);
      idle(1, 0);
      idle(8, 1);

      // reset with a change pending
      step(1, 1, 1, 5);
      idle(1, 1);
      step(0, 1, 0, 0);
      idle(3, 0);
      idle(5, 1);

      // load 4 while stopped
      idle(10, 0);
      step(1, 0, 1, 4);
      idle(2, 0);
      idle(17, 1);

      for (int i = 0; i < 600; i++) begin
         bit rn, en, v;
         int h;
         rn = ($urandom_range(0, 99) != 0);
         en = ($urandom_range(0, 9) < 8);
         v  = ($urandom_range(0, 4) == 0);
         h  = $urandom_range(0, 15);
         step(rn, en, v, h);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/clk_div_ratio_ctrl.md
Name: clk_div_ratio_ctrl

Overview:
- Runtime-programmable, glitch-free even-ratio clock divider controller.
- Produces a divided clock enable/waveform `clk_out` with period 2*half input cycles.
- Accepts ratio changes over a valid/ready config handshake and applies each change only at an output period boundary, so no period is ever truncated or stretched.
- Also sequences clean start/stop of the output. Sits between the config/CSR logic and the fixed even dividers as their shared ratio-changing front end.

Parameters:
- CW, 4, width of the half-period fields.
- MAX_HALF, 8, largest legal half-period in input cycles; must be <= 2^CW-1.
- DEFAULT_HALF, 1, half-period loaded at reset (1 = divide-by-2).

Ports:
- clk  input  1  input clock.
- resetn  input  1  reset, synchronous, active-low.
- enable  input  1  run request for the output clock.
- cfg_valid  input  1  new half-period offered.
- cfg_half  input  CW  requested half-period, in input cycles.
- cfg_ready  output  1  controller can accept a request.
- cfg_err  output  1  one-cycle pulse: illegal request rejected.
- clk_out  output  1  divided clock, registered.
- period_start  output  1  high in the cycle clk_out rises.
- cur_half  output  CW  half-period currently in effect.
- busy  output  1  a change is pending.

Behaviour:
- Reset, while resetn=0 at posedge clk:
  - clk_out=0, period_start=0, cfg_err=0, busy=0, cfg_ready=1.
  - cur_half=DEFAULT_HALF; half counter hc=0; state=STOP.
  - Any pending request is discarded. Reset mid-period aborts that period; there is no resume.
- States:
  - STOP: clk_out held 0.
  - RUN: clk_out toggling.
  - DRAIN: finishing the current period before stopping.
- STOP -> RUN: the first cycle enable=1. In that cycle clk_out<=1, period_start<=1, hc<=0.
- RUN, each cycle:
  - If hc==cur_half-1: clk_out<=~clk_out, hc<=0.
  - Else: hc<=hc+1.
  - Resulting waveforms: half=1 gives 1,0,1,0…; half=3 gives 1,1,1,0,0,0.
- Boundary: cycle with clk_out==0 and hc==cur_half-1, i.e. the next edge is a rise. period_start<=1 on every rise.
- RUN -> DRAIN: when enable=0 is sampled.
- DRAIN:
  - Counts exactly as RUN.
  - At boundary: goes to STOP, clk_out stays 0, no rise, period_start stays 0.
  - enable=1 sampled in DRAIN returns to RUN with no disturbance to the waveform.
- Config handshake:
  - Transfer when cfg_valid & cfg_ready.
  - Legal range 1..MAX_HALF. Illegal value (0 or >MAX_HALF): cfg_err=1 next cycle, nothing latched, cfg_ready stays 1.
  - Legal value: latched into pend_half; busy<=1 and cfg_ready<=0 next cycle.
- Apply:
  - RUN/DRAIN: applied at the first boundary strictly after the accept cycle. In that boundary cycle, cur_half<=pend_half, hc<=0, and the rise proceeds (or stop, if in DRAIN).
  - STOP: applied the cycle after accept, with no clk_out activity.
  - busy<=0 and cfg_ready<=1 in the same update as cur_half.
- Simultaneous events:
  - Accept on a boundary cycle is applied at the following boundary, not the current one.
  - Apply and enable-drop in the same cycle: both take effect; new cur_half is stored, the output stops.
  - Reset overrides everything.
- Width rules:
  - hc is CW bits.
  - Compare against cur_half-1 without underflow; cur_half is never 0.

Test Plan:
- Reset, then enable=1 held, cur_half=1 → clk_out=1,0,1,0 starting the cycle after enable is sampled; period_start high on each rise.
- Request cfg_half=3 mid-high half of a div-2 period → cfg_ready low and busy high until the next rise; then clk_out shows 3 high, 3 low; cur_half=3; no short pulse.
- cfg_half=0, then cfg_half=9 (MAX_HALF=8) → cfg_err pulses once each; cur_half unchanged; cfg_ready stays 1.
- half=2 running, enable dropped at the first high cycle → output completes 1,1,0,0 then holds 0. Re-enable inside DRAIN → continuous waveform, no gap.
- resetn pulsed low mid-period with a request pending → clk_out=0, cur_half=DEFAULT_HALF, busy=0 after release; the first enable starts a full new period.
- In STOP, accept cfg_half=4 → cur_half=4 one cycle later, clk_out stays 0; enable → 4 high, 4 low.
